// File: rtl/lock_pkg.sv
// Shared types and defaults for the bathysphere airlock sequencer.
package lock_pkg;

    typedef enum logic [3:0] {
        IDLE,
        PUMP_PRE,
        OPEN_A,
        WAIT_IN,
        CLOSE_A,
        PUMP_XFER,
        OPEN_B,
        WAIT_OUT,
        CLOSE_B,
        ABORT
    } lock_state_t;

    typedef struct packed {
        logic outer_open;
        logic inner_open;
        logic filling;
        logic draining;
    } lock_cmd_t;

    localparam logic DIR_ARR = 1'b1;
    localparam logic DIR_DEP = 1'b0;

    localparam int LEVEL_MAX_DEFAULT     = 7;
    localparam int GATE_TICKS_DEFAULT    = 2;
    localparam int TIMEOUT_TICKS_DEFAULT = 10;

    // Entry side is the outer gate for arrivals, inner gate for departures.
    // Pumps are only ever commanded in pump states, where both gates are shut.
    function automatic lock_cmd_t decode_cmd(lock_state_t s, logic dir,
                                             logic below_target, logic above_target);
        lock_cmd_t cmd;
        cmd = '0;
        case (s)
            PUMP_PRE, PUMP_XFER: begin
                cmd.filling  = below_target;
                cmd.draining = above_target;
            end
            OPEN_A, WAIT_IN: begin
                cmd.outer_open = (dir == DIR_ARR);
                cmd.inner_open = (dir == DIR_DEP);
            end
            OPEN_B, WAIT_OUT: begin
                cmd.outer_open = (dir == DIR_DEP);
                cmd.inner_open = (dir == DIR_ARR);
            end
            default: cmd = '0;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/lock_cycle_controller_if.sv
// Request, sensor and command signals between the airlock sequencer and its surroundings.
interface lock_cycle_controller_if #(
    parameter int LEVEL_W = 3
);
    logic               tick;
    logic               arriving;
    logic               departing;
    logic               occupied;
    logic               outer_open;
    logic               inner_open;
    logic               filling;
    logic               draining;
    logic [LEVEL_W-1:0] level;
    logic               busy;
    logic               serving_arrival;

    modport master (
        output tick, arriving, departing, occupied,
        input  outer_open, inner_open, filling, draining, level, busy, serving_arrival
    );

    modport slave (
        input  tick, arriving, departing, occupied,
        output outer_open, inner_open, filling, draining, level, busy, serving_arrival
    );
endinterface

// File: rtl/lock_tick_timer.sv
// Loadable down-counter advanced by the 1 Hz tick; done while the count sits at zero.
module lock_tick_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         done
);
    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (tick && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);
endmodule

// File: rtl/lock_cycle_controller.sv
// Airlock sequencer: arbitrates arrival/departure requests and walks the chamber
// through gate/pump phases against a modelled water level.
//
// state     | meaning
// IDLE      | waiting for a request, round-robin arbitration
// PUMP_PRE  | pump chamber to the entry side's level
// OPEN_A    | entry gate travelling open
// WAIT_IN   | entry gate open, waiting for the bathysphere (with timeout)
// CLOSE_A   | entry gate travelling closed
// PUMP_XFER | pump chamber to the exit side's level
// OPEN_B    | exit gate travelling open
// WAIT_OUT  | exit gate open, waiting for the chamber to empty
// CLOSE_B   | exit gate travelling closed
// ABORT     | entry timed out, entry gate travelling closed
module lock_cycle_controller
    import lock_pkg::*;
#(
    parameter int LEVEL_MAX     = LEVEL_MAX_DEFAULT,
    parameter int LEVEL_W       = 3,
    parameter int GATE_TICKS    = GATE_TICKS_DEFAULT,
    parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    lock_cycle_controller_if.slave  bus
);
    localparam int TIMER_MAX = (TIMEOUT_TICKS > GATE_TICKS) ? TIMEOUT_TICKS : GATE_TICKS;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

    localparam logic [LEVEL_W-1:0] LVL_FULL = LEVEL_W'(LEVEL_MAX);
    localparam logic [TIMER_W-1:0] T_GATE   = TIMER_W'(GATE_TICKS);
    localparam logic [TIMER_W-1:0] T_WAIT   = TIMER_W'(TIMEOUT_TICKS);

    lock_state_t        state, state_next;
    logic               dir, dir_next;
    logic               prio_arr, prio_arr_next;
    logic [LEVEL_W-1:0] level_q, level_next;
    logic [LEVEL_W-1:0] entry_lvl, exit_lvl;
    logic [LEVEL_W-1:0] entry_lvl_next, exit_lvl_next, target_next;
    lock_cmd_t          cmd_next, cmd_q;
    logic               busy_q;
    logic               timer_load, timer_done;
    logic [TIMER_W-1:0] timer_value;

    assign entry_lvl      = (dir == DIR_ARR) ? LVL_FULL : '0;
    assign exit_lvl       = (dir == DIR_ARR) ? '0 : LVL_FULL;
    assign entry_lvl_next = (dir_next == DIR_ARR) ? LVL_FULL : '0;
    assign exit_lvl_next  = (dir_next == DIR_ARR) ? '0 : LVL_FULL;

    always_comb begin
        state_next    = state;
        dir_next      = dir;
        prio_arr_next = prio_arr;
        level_next    = level_q;
        case (state)
            IDLE: begin
                if (bus.arriving && bus.departing) begin
                    dir_next      = prio_arr ? DIR_ARR : DIR_DEP;
                    prio_arr_next = ~prio_arr;
                    state_next    = PUMP_PRE;
                end else if (bus.arriving) begin
                    dir_next   = DIR_ARR;
                    state_next = PUMP_PRE;
                end else if (bus.departing) begin
                    dir_next   = DIR_DEP;
                    state_next = PUMP_PRE;
                end
            end
            PUMP_PRE: begin
                if (level_q == entry_lvl) begin
                    state_next = OPEN_A;
                end else if (bus.tick) begin
                    level_next = (level_q < entry_lvl) ? level_q + LEVEL_W'(1)
                                                       : level_q - LEVEL_W'(1);
                end
            end
            OPEN_A: if (timer_done) state_next = WAIT_IN;
            WAIT_IN: begin
                if (bus.occupied) begin
                    state_next = CLOSE_A;
                end else if (timer_done) begin
                    state_next = ABORT;
                end
            end
            CLOSE_A: if (timer_done) state_next = PUMP_XFER;
            PUMP_XFER: begin
                if (level_q == exit_lvl) begin
                    state_next = OPEN_B;
                end else if (bus.tick) begin
                    level_next = (level_q < exit_lvl) ? level_q + LEVEL_W'(1)
                                                      : level_q - LEVEL_W'(1);
                end
            end
            OPEN_B:   if (timer_done) state_next = WAIT_OUT;
            WAIT_OUT: if (!bus.occupied) state_next = CLOSE_B;
            CLOSE_B, ABORT: if (timer_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Reload on every state entry so the first cycle of a state already counts ticks.
    assign timer_load  = (state_next != state);
    assign timer_value = (state_next == WAIT_IN) ? T_WAIT : T_GATE;

    // Commands are registered from the next state and level, so they line up with the state register.
    assign target_next = (state_next == PUMP_XFER) ? exit_lvl_next : entry_lvl_next;
    assign cmd_next    = decode_cmd(state_next, dir_next,
                                    level_next < target_next, level_next > target_next);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            dir      <= DIR_DEP;
            prio_arr <= 1'b1;
            level_q  <= '0;
            cmd_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_next;
            dir      <= dir_next;
            prio_arr <= prio_arr_next;
            level_q  <= level_next;
            cmd_q    <= cmd_next;
            busy_q   <= (state_next != IDLE);
        end
    end

    lock_tick_timer #(
        .W (TIMER_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .tick       (bus.tick),
        .load       (timer_load),
        .load_value (timer_value),
        .done       (timer_done)
    );

    assign bus.outer_open      = cmd_q.outer_open;
    assign bus.inner_open      = cmd_q.inner_open;
    assign bus.filling         = cmd_q.filling;
    assign bus.draining        = cmd_q.draining;
    assign bus.level           = level_q;
    assign bus.busy            = busy_q;
    assign bus.serving_arrival = dir;
endmodule

// File: tb/tb_lock_cycle_controller.sv
// Directed and random bench for the airlock sequencer.
module tb_lock_cycle_controller;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    lock_cycle_controller_if #(.LEVEL_W(3)) bus ();

    lock_cycle_controller #(
        .LEVEL_MAX     (7),
        .LEVEL_W       (3),
        .GATE_TICKS    (2),
        .TIMEOUT_TICKS (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            checks++;
            if ((bus.outer_open & bus.inner_open) !== 1'b0) begin
                errors++;
                $display("FAIL gate_interlock: outer=%b inner=%b want not both", bus.outer_open, bus.inner_open);
            end
            checks++;
            if ((bus.filling & bus.draining) !== 1'b0) begin
                errors++;
                $display("FAIL pump_interlock: fill=%b drain=%b want not both", bus.filling, bus.draining);
            end
            checks++;
            if (((bus.filling | bus.draining) & (bus.outer_open | bus.inner_open)) !== 1'b0) begin
                errors++;
                $display("FAIL pump_gate_interlock: pump=%b gate=%b want gates shut while pumping",
                         bus.filling | bus.draining, bus.outer_open | bus.inner_open);
            end
            checks++;
            if ((!bus.busy & (bus.filling | bus.draining | bus.outer_open | bus.inner_open)) !== 1'b0) begin
                errors++;
                $display("FAIL idle_quiet: busy=%b cmds=%b%b%b%b want no commands when idle", bus.busy,
                         bus.outer_open, bus.inner_open, bus.filling, bus.draining);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_ticks(input int n);
        repeat (n) begin
            bus.tick = 1'b1;
            step();
            bus.tick = 1'b0;
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.tick = 1'b0;
        bus.arriving = 1'b0;
        bus.departing = 1'b0;
        bus.occupied = 1'b0;
        step();
        step();
        checks++;
        if ({bus.outer_open, bus.inner_open, bus.filling, bus.draining, bus.busy, bus.serving_arrival} !== 6'b0
            || bus.level !== 3'd0) begin
            errors++;
            $display("FAIL reset_outputs: cmds/busy/dir=%b level=%0d want all 0",
                     {bus.outer_open, bus.inner_open, bus.filling, bus.draining, bus.busy, bus.serving_arrival},
                     bus.level);
        end
        reset = 1'b1;
        step();
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b want 0", bus.busy);
        end
    endtask

    // One full cycle; pre = ticks of pre-pumping needed to reach the entry level.
    task automatic serve(input string name, input logic a, input logic d, input logic exp_arr, input int pre);
        logic [2:0] entry_lvl, exit_lvl;
        entry_lvl = exp_arr ? 3'd7 : 3'd0;
        exit_lvl  = exp_arr ? 3'd0 : 3'd7;
        bus.arriving  = a;
        bus.departing = d;
        step();
        bus.arriving  = 1'b0;
        bus.departing = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.serving_arrival !== exp_arr) begin
            errors++;
            $display("FAIL %s accept: busy=%b dir=%b want busy=1 dir=%b", name, bus.busy, bus.serving_arrival, exp_arr);
        end
        checks++;
        if (pre == 0) begin
            if ((bus.filling | bus.draining) !== 1'b0) begin
                errors++;
                $display("FAIL %s no_prepump: fill=%b drain=%b want 0", name, bus.filling, bus.draining);
            end
            step();
        end else begin
            if ((exp_arr ? bus.filling : bus.draining) !== 1'b1) begin
                errors++;
                $display("FAIL %s prepump: fill=%b drain=%b want pump toward entry", name, bus.filling, bus.draining);
            end
            pulse_ticks(pre);
        end
        checks++;
        if ((exp_arr ? bus.outer_open : bus.inner_open) !== 1'b1 || bus.level !== entry_lvl) begin
            errors++;
            $display("FAIL %s entry_open: outer=%b inner=%b level=%0d want entry gate open at level %0d",
                     name, bus.outer_open, bus.inner_open, bus.level, entry_lvl);
        end
        pulse_ticks(2);
        bus.occupied = 1'b1;
        step();
        checks++;
        if ((bus.outer_open | bus.inner_open) !== 1'b0) begin
            errors++;
            $display("FAIL %s entry_close: outer=%b inner=%b want 0", name, bus.outer_open, bus.inner_open);
        end
        pulse_ticks(2);
        checks++;
        if ((exp_arr ? bus.draining : bus.filling) !== 1'b1) begin
            errors++;
            $display("FAIL %s xfer_pump: fill=%b drain=%b want pump toward exit", name, bus.filling, bus.draining);
        end
        pulse_ticks(7);
        checks++;
        if ((exp_arr ? bus.inner_open : bus.outer_open) !== 1'b1 || bus.level !== exit_lvl
            || bus.serving_arrival !== exp_arr) begin
            errors++;
            $display("FAIL %s exit_open: outer=%b inner=%b level=%0d dir=%b want exit gate open at level %0d",
                     name, bus.outer_open, bus.inner_open, bus.level, bus.serving_arrival, exit_lvl);
        end
        pulse_ticks(2);
        bus.occupied = 1'b0;
        step();
        checks++;
        if ((bus.outer_open | bus.inner_open) !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL %s exit_close: outer=%b inner=%b busy=%b want gates 0 busy 1",
                     name, bus.outer_open, bus.inner_open, bus.busy);
        end
        pulse_ticks(2);
        checks++;
        if (bus.busy !== 1'b0 || bus.level !== exit_lvl) begin
            errors++;
            $display("FAIL %s done_idle: busy=%b level=%0d want busy 0 level %0d", name, bus.busy, bus.level, exit_lvl);
        end
    endtask

    task automatic test_arrival();
        serve("arrival", 1'b1, 1'b0, 1'b1, 7);
    endtask

    task automatic test_departure();
        serve("departure", 1'b0, 1'b1, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        serve("rr_first", 1'b1, 1'b1, 1'b1, 0);
        serve("rr_second", 1'b1, 1'b1, 1'b0, 0);
    endtask

    task automatic test_timeout();
        bus.arriving = 1'b1;
        step();
        bus.arriving = 1'b0;
        step();
        checks++;
        if (bus.outer_open !== 1'b1) begin
            errors++;
            $display("FAIL timeout_open: outer=%b want 1", bus.outer_open);
        end
        pulse_ticks(2);
        pulse_ticks(9);
        checks++;
        if (bus.outer_open !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early: outer=%b want 1 after 9 ticks", bus.outer_open);
        end
        pulse_ticks(1);
        checks++;
        if (bus.outer_open !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_abort: outer=%b busy=%b want 0 1", bus.outer_open, bus.busy);
        end
        pulse_ticks(2);
        checks++;
        if (bus.busy !== 1'b0 || bus.level !== 3'd7) begin
            errors++;
            $display("FAIL timeout_idle: busy=%b level=%0d want 0 7", bus.busy, bus.level);
        end
    endtask

    task automatic test_reset_mid();
        bus.arriving = 1'b1;
        step();
        bus.arriving = 1'b0;
        step();
        pulse_ticks(2);
        bus.occupied = 1'b1;
        step();
        pulse_ticks(2);
        pulse_ticks(3);
        checks++;
        if (bus.level !== 3'd4 || bus.draining !== 1'b1) begin
            errors++;
            $display("FAIL midreset_setup: level=%0d drain=%b want 4 1", bus.level, bus.draining);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.outer_open, bus.inner_open, bus.filling, bus.draining, bus.busy, bus.serving_arrival} !== 6'b0
            || bus.level !== 3'd0) begin
            errors++;
            $display("FAIL midreset_async: cmds/busy/dir=%b level=%0d want all 0",
                     {bus.outer_open, bus.inner_open, bus.filling, bus.draining, bus.busy, bus.serving_arrival},
                     bus.level);
        end
        bus.occupied = 1'b0;
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            bus.tick      = ($urandom_range(0, 2) == 0);
            bus.arriving  = ($urandom_range(0, 15) == 0);
            bus.departing = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) bus.occupied = ~bus.occupied;
            step();
        end
        bus.tick = 1'b0;
        bus.arriving = 1'b0;
        bus.departing = 1'b0;
        bus.occupied = 1'b0;
    endtask

    initial begin
        test_reset();
        test_arrival();
        test_departure();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lock_cycle_controller.md
Name: lock_cycle_controller

Overview:
- Sequences the bathysphere airlock chamber between the outer (flooded, ocean) gate and the inner (drained, habitat) gate.
- Accepts the debounced `arriving`/`departing` request levels produced by the bathysphere arrival/departure indicator and arbitrates between them.
- Drives gate and pump commands and keeps a model of chamber water level, advancing one step per 1-second `tick` from the clock divider.
- Enforces gate/pump interlocks in hardware.

Parameters:
LEVEL_MAX, 7, chamber level when fully flooded (equal to the ocean level); 0 means fully drained (habitat level)
LEVEL_W, 3, width of the level counter; must satisfy LEVEL_MAX < 2**LEVEL_W
GATE_TICKS, 2, ticks of gate travel time per open or close
TIMEOUT_TICKS, 10, ticks to wait for the bathysphere to enter before aborting

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
tick  input  1  single-cycle 1 Hz strobe; all timers and level changes advance only on cycles where tick=1
arriving  input  1  request level: bathysphere waiting at the outer gate
departing  input  1  request level: bathysphere waiting at the inner gate
occupied  input  1  chamber occupancy sensor (1 = bathysphere inside)
outer_open  output  1  command to open the outer gate
inner_open  output  1  command to open the inner gate
filling  output  1  pump command: flood the chamber
draining  output  1  pump command: drain the chamber
level  output  LEVEL_W  modelled chamber water level
busy  output  1  1 whenever state != IDLE
serving_arrival  output  1  direction of the current or last cycle (1 = arrival)

Behaviour:
Reset (reset=0, asynchronous):
- State goes to IDLE; level=0; all gate and pump outputs 0; busy=0; serving_arrival=0; priority=arrival.
- Reset asserted mid-cycle aborts immediately. No outputs are held.

Arbitration (evaluated in IDLE only, every clk edge, not gated by tick):
- Only one request high: accept that request.
- Both high: accept the direction holding round-robin priority. Priority then flips to the other direction.
- On accept, the next edge sets busy=1, latches serving_arrival, and leaves IDLE. Latency from request to busy is 1 clk.
- Requests are ignored while busy. Dropping a request after accept does not abort the cycle.

Sides:
- Arrival: entry = outer, entry level = LEVEL_MAX, exit = inner, exit level = 0.
- Departure: entry = inner, entry level = 0, exit = outer, exit level = LEVEL_MAX.

State machine (timer reloads on state entry and decrements on tick):
- IDLE: behaves as the arbitration rules above.
- PUMP_PRE: if level == entry level, go to OPEN_A on the next edge without waiting for a tick. Otherwise filling or draining is held high, and each tick moves level ±1 toward the entry level.
- OPEN_A: entry gate output = 1. After GATE_TICKS ticks, go to WAIT_IN.
- WAIT_IN: entry gate held open.
  - occupied=1 → CLOSE_A.
  - TIMEOUT_TICKS ticks with occupied=0 → ABORT.
- CLOSE_A: entry gate = 0. After GATE_TICKS ticks, go to PUMP_XFER.
- PUMP_XFER: pump level toward the exit level, one step per tick. On equality, go to OPEN_B.
- OPEN_B: exit gate = 1. After GATE_TICKS ticks, go to WAIT_OUT.
- WAIT_OUT: exit gate held open. Waits for occupied=0 with no timeout, then → CLOSE_B.
- CLOSE_B and ABORT: all gates = 0. After GATE_TICKS ticks, go to IDLE.
- Gate commands and pump commands are Moore outputs, registered from state.

Interlocks (must hold every cycle):
- outer_open & inner_open == 0.
- filling & draining == 0.
- (filling | draining) implies both gates closed.
- level never leaves the range [0, LEVEL_MAX]; no wrap-around.

Edge cases:
- A tick that coincides with a state entry counts for the new state's timer.
- occupied glitching high in WAIT_OUT is ignored until it is seen low.

Decomposition:
- Shared package `lock_pkg`:
  - state enum: IDLE, PUMP_PRE, OPEN_A, WAIT_IN, CLOSE_A, PUMP_XFER, OPEN_B, WAIT_OUT, CLOSE_B, ABORT.
  - direction constants: DIR_ARR, DIR_DEP.
  - default LEVEL_MAX, GATE_TICKS, TIMEOUT_TICKS.
- One sub-module, `lock_tick_timer`: a loadable down-counter that decrements on tick and asserts `done` at zero. It is shared by the gate-travel and timeout waits.

Test Plan:
1. Arrival from reset (level=0): pulse arriving.
   - busy=1 after 1 clk; 7 ticks of filling take level to 7.
   - outer_open for 2 ticks, then hold occupied=1 → outer closes for 2 ticks.
   - 7 ticks of draining take level to 0; inner_open asserts; drop occupied → IDLE after 2 ticks.
2. Departure with level=0: no pre-pump; inner_open asserts on the next edge.
   - After the transfer, level=7, outer_open=1, serving_arrival=0.
3. Simultaneous arriving=departing=1 in IDLE twice in a row: the first cycle serves arrival, the second serves departure.
4. Timeout: arrival accepted, occupied stays 0 for 10 ticks → ABORT, outer closes, IDLE after 2 ticks, level stays 7.
5. Reset asserted during PUMP_XFER at level=4: all outputs 0 and level=0 asynchronously, with no clk edge required.
6. Assertion monitor across random request/occupied/tick stimulus: the interlocks never fail, and level stays within [0, 7].
